ipi_axi_master: RTL
===================

IPI_AXI_MASTER -- requirements
Module: ipi_axi_master

Interface
REQ-001 Parameter TIMEOUT, 256, cycles allowed from request accept to AXI completion before abort (≥4).
REQ-002 aclk  in  1  clock, all logic rising-edge.
REQ-003 areset  in  1  reset, synchronous, active-high; clock aclk.
REQ-004 req_valid  in  1  core request present.
REQ-005 req_ready  out  1  block idle, request accepted this cycle if req_valid.
REQ-006 req_write  in  1  1=write msip/ssip register, 0=read.
REQ-007 req_addr  in  32  target byte address.
REQ-008 req_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  32  read data; 0 for writes.
REQ-011 rsp_err  out  1  completion failed (bad resp, misalignment, rlast=0, timeout).
REQ-012 rsp_timeout  out  1  failure cause was timeout; valid with rsp_valid.
REQ-013 AXI master ports: awaddr out 32, awvalid out 1, awready in 1, wdata out 32, wlast out 1, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1, araddr out 32, arvalid out 1, arready in 1, rdata in 32, rresp in 2, rvalid in 1, rlast in 1, rready out 1.

Function
REQ-014 FSM states IDLE, WRITE, WRESP, READ, RDATA, DONE; all outputs driven from registers.
REQ-015 req_ready=1 only in IDLE; one outstanding request max.
REQ-016 On accept: latch addr/wdata/write, clear timeout counter; misaligned addr (addr[1:0]!=0) -> DONE with rsp_err=1, no AXI activity.
REQ-017 Aligned write: next cycle awvalid=wvalid=wlast=1 with awaddr/wdata; state WRITE.
REQ-018 In WRITE, awvalid drops the cycle after awvalid&&awready and wvalid/wlast drop the cycle after wvalid&&wready, independently, in any order or the same cycle; both done -> WRESP.
REQ-019 In WRESP, bready=1 until bvalid; bvalid while bready=0 ignored; on handshake capture bresp, bready drops -> DONE.
REQ-020 Aligned read: next cycle arvalid=1 with araddr; drop after arvalid&&arready -> RDATA.
REQ-021 In RDATA, rready=1 until rvalid; capture rdata, rresp, rlast -> DONE.
REQ-022 DONE: rsp_valid=1 for exactly one cycle; rsp_err=1 if captured resp!=2'b00 or read rlast=0; then IDLE.
REQ-023 Valids and addr/data held stable until their handshake (AXI rule).
REQ-024 Timeout counter increments each cycle outside IDLE/DONE, saturating; at TIMEOUT-1, all AXI valids/readies drop next cycle, -> DONE with rsp_err=rsp_timeout=1.
REQ-025 Handshake on the same cycle as the timeout is honoured; timeout suppressed.
REQ-026 Accept-to-rsp_valid latency with zero-wait slave: write 4 cycles, read 4 cycles, misaligned 1 cycle.

Reset
REQ-027 areset: state IDLE, counter 0; req_ready=1 on the first cycle after reset; all other outputs 0 (rsp_*, awvalid, wvalid, wlast, bready, arvalid, rready, awaddr, wdata, araddr).
REQ-028 Reset mid-transaction aborts silently: no rsp_valid, valids drop next cycle.

Structure
REQ-029 Shared package ipi_axi_pkg holds AXI response codes OKAY/EXOKAY/SLVERR/DECERR, FSM state enum, and default CLINT addresses MSIP0=0x02000000, MSIP1=0x02000004, SSIP0=0x0200C000, SSIP1=0x0200C004.
REQ-030 One sub-module ipi_axi_timeout (load/enable/expire saturating counter, width from TIMEOUT); everything else flat.

Verification
REQ-031 Write 0x1 to 0x02000000, slave zero-wait, bresp=OKAY -> awaddr=0x02000000, wdata=1, wlast=1, rsp_valid 4 cycles after accept, rsp_err=0.
REQ-032 Write with wready 3 cycles before awready, bvalid held 2 cycles early -> wvalid drops first, bready only after both handshakes, single rsp_valid, rsp_err=0.
REQ-033 Read 0x0200C004, rdata=0x1, rresp=OKAY, rlast=1 -> rsp_rdata=0x1, rsp_err=0; same with rlast=0 -> rsp_err=1.
REQ-034 Read with rresp=DECERR -> rsp_err=1, rsp_timeout=0; req_addr=0x02000002 -> rsp_valid next cycle, rsp_err=1, no awvalid/arvalid.
REQ-035 TIMEOUT=8, awready never asserted -> valids drop, rsp_valid with rsp_err=rsp_timeout=1 at the TIMEOUT boundary; next request accepted.
REQ-036 areset during WRESP -> no rsp_valid, all outputs 0 and req_ready=1 on the cycle after reset release.

Source files
------------

// File: rtl/ipi_axi_pkg.sv
// Shared definitions for the IPI AXI master: AXI response codes, FSM states,
// bus widths and the default CLINT software-interrupt register addresses.
package ipi_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] MSIP0 = 32'h0200_0000;
  localparam logic [ADDR_W-1:0] MSIP1 = 32'h0200_0004;
  localparam logic [ADDR_W-1:0] SSIP0 = 32'h0200_C000;
  localparam logic [ADDR_W-1:0] SSIP1 = 32'h0200_C004;

endpackage

// File: rtl/ipi_axi_master_if.sv
// AXI4 single-beat bus between the IPI master and a slave.
// master: drives AW/W/AR channels and B/R readies; slave: the mirror image.
interface ipi_axi_master_if;
  import ipi_axi_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rlast;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
  );

endinterface

// File: rtl/ipi_axi_timeout.sv
// Saturating transaction-age counter.
// Ports: aclk/areset (sync, active-high), load clears the count, en advances it,
// expire_c is high while the count sits at TIMEOUT-1.
module ipi_axi_timeout #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic aclk,
  input  logic areset,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count up to LAST and hold there until reloaded.
  always_ff @(posedge aclk) begin
    if (areset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expire_c = (count == LAST);

endmodule

// File: rtl/ipi_axi_master.sv
// Turns one core IPI register request at a time into a single-beat AXI
// write or read and reports a one-cycle completion with error/timeout flags.
// Ports: aclk/areset (sync, active-high); req_* request handshake from the core;
// rsp_* completion pulse; axi = AXI master bus. All outputs are registered.
module ipi_axi_master
  import ipi_axi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  ipi_axi_master_if.master  axi
);

  state_e            state_q, state_d;
  logic              awvalid_d, wvalid_d, wlast_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic [DATA_W-1:0] wdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic              tmo_load, tmo_en, tmo_expire_c;
  logic              aw_left, w_left;

  assign tmo_en = (state_q == WRITE) || (state_q == WRESP) ||
                  (state_q == READ)  || (state_q == RDATA);

  ipi_axi_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .aclk     (aclk),
    .areset   (areset),
    .load     (tmo_load),
    .en       (tmo_en),
    .expire_c (tmo_expire_c)
  );

  // Channel still pending after this cycle (valid high and no ready).
  assign aw_left = axi.awvalid && !axi.awready;
  assign w_left  = axi.wvalid  && !axi.wready;

  // Next state and next register values. A completing handshake always
  // wins over an expiring timeout in the same cycle.
  always_comb begin
    state_d       = state_q;
    awaddr_d      = axi.awaddr;
    awvalid_d     = axi.awvalid;
    wdata_d       = axi.wdata;
    wvalid_d      = axi.wvalid;
    wlast_d       = axi.wlast;
    araddr_d      = axi.araddr;
    arvalid_d     = axi.arvalid;
    bready_d      = 1'b0;
    rready_d      = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    tmo_load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          tmo_load = 1'b1;
          if (req_addr[1:0] != 2'b00) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_write) begin
            state_d   = WRITE;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wlast_d   = 1'b1;
          end else begin
            state_d   = READ;
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        wlast_d   = w_left;
        if (!aw_left && !w_left) begin
          state_d = WRESP;
        end else if (tmo_expire_c) begin
          awvalid_d     = 1'b0;
          wvalid_d      = 1'b0;
          wlast_d       = 1'b0;
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      WRESP: begin
        if (axi.bvalid && axi.bready) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (axi.bresp != OKAY);
        end else if (tmo_expire_c) begin
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          bready_d = 1'b1;
        end
      end
      READ: begin
        if (axi.arvalid && axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end else if (tmo_expire_c) begin
          arvalid_d     = 1'b0;
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RDATA: begin
        if (axi.rvalid && axi.rready) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = axi.rdata;
          rsp_err_d   = (axi.rresp != OKAY) || !axi.rlast;
        end else if (tmo_expire_c) begin
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          rready_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wvalid  <= 1'b0;
      axi.wlast   <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready   <= (state_d == IDLE);
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      axi.awaddr  <= awaddr_d;
      axi.awvalid <= awvalid_d;
      axi.wdata   <= wdata_d;
      axi.wvalid  <= wvalid_d;
      axi.wlast   <= wlast_d;
      axi.bready  <= bready_d;
      axi.araddr  <= araddr_d;
      axi.arvalid <= arvalid_d;
      axi.rready  <= rready_d;
    end
  end

endmodule
